way_replace_ctrl: RTL and testbench
===================================

WAY_REPLACE_CTRL -- requirements
Module: way_replace_ctrl

Interface
REQ-001 Parameter NUM_SETS, 16, number of cache sets tracked.
REQ-002 Parameter INDEX_W, 4, set-index width; SHALL equal log2(NUM_SETS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  cache lookup result presented this cycle.
REQ-006 req_ready  output  1  block accepts a lookup this cycle.
REQ-007 req_index  input  INDEX_W  set index of the lookup.
REQ-008 req_hit  input  1  lookup hit in either way.
REQ-009 req_hit_way  input  1  way that hit; valid only when req_hit=1.
REQ-010 victim_way  output  1  way to be refilled; drives decIn of the 1-to-2 way decoder.
REQ-011 fill_req  output  1  request line fill from next-level memory.
REQ-012 fill_index  output  INDEX_W  set index of the pending fill.
REQ-013 fill_done  input  1  memory returned fill data (single-cycle pulse).
REQ-014 wr_en  output  1  one-cycle write strobe qualifying the decoded way select.
REQ-015 miss_count  output  16  saturating count of accepted misses.
REQ-016 hit_count  output  16  saturating count of accepted hits.

Function
REQ-017 Block SHALL hold one LRU bit per set; bit value = least-recently-used way = next victim.
REQ-018 FSM SHALL have states IDLE, FILL, COMMIT.
REQ-019 req_ready SHALL be 1 in IDLE only; handshake occurs when req_valid & req_ready.
REQ-020 IDLE, accepted hit: lru[req_index] <= ~req_hit_way next edge; hit_count increments; state stays IDLE (zero-stall).
REQ-021 IDLE, accepted miss: latch fill_index <= req_index, victim_way <= lru[req_index]; miss_count increments; next state FILL.
REQ-022 FILL: fill_req SHALL be 1 every cycle; on fill_done=1 next state COMMIT; otherwise stay, no timeout.
REQ-023 COMMIT: wr_en=1 for exactly this cycle; lru[fill_index] <= ~victim_way; next state IDLE.
REQ-024 Miss-to-wr_en latency SHALL be N+2 cycles where N = cycles from FILL entry to fill_done (min 1).
REQ-025 victim_way and fill_index SHALL remain stable from FILL entry through COMMIT.
REQ-026 req_valid while req_ready=0 SHALL be ignored (no LRU, counter or state change).
REQ-027 fill_done outside FILL SHALL be ignored.
REQ-028 req_hit_way SHALL be ignored when req_hit=0.
REQ-029 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-030 Only the indexed set's LRU bit SHALL change on any update; other sets unchanged.
REQ-031 wr_en and fill_req SHALL never be 1 in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, all LRU bits 0, victim_way 0, fill_index 0, fill_req 0, wr_en 0, both counters 0.
REQ-033 req_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-034 Reset asserted during FILL or COMMIT SHALL abort the fill with no wr_en pulse and no LRU update.

Verification
REQ-035 After reset, miss on index 3, fill_done 2 cycles later -> victim_way=0, fill_index=3, wr_en pulse once, lru[3]=1, miss_count=1.
REQ-036 Hit index 5 way 0, then miss index 5 -> victim_way=1; after commit lru[5]=0; hit_count=1, miss_count=1.
REQ-037 Back-to-back hits on index 7 ways 1,0,1 over three cycles -> req_ready stays 1, lru[7]=0, hit_count=3.
REQ-038 req_valid hit during FILL, plus stray fill_done in IDLE -> no counter or LRU change, no wr_en.
REQ-039 rst_n low mid-FILL (index 9) -> fill_req 0 immediately, no wr_en, lru[9]=0, counters 0.
REQ-040 Preload hit_count to 16'hFFFE via 3 hits after forcing -> value holds at 16'hFFFF.

Source files
------------

// File: rtl/way_replace_if.sv
// Lookup / fill handshake bundle between the cache datapath and the way replacement controller.
interface way_replace_if #(
  parameter int INDEX_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [INDEX_W-1:0] req_index;
  logic               req_hit;
  logic               req_hit_way;
  logic               victim_way;
  logic               fill_req;
  logic [INDEX_W-1:0] fill_index;
  logic               fill_done;
  logic               wr_en;
  logic [15:0]        miss_count;
  logic [15:0]        hit_count;

  modport slave (
    input  req_valid, req_index, req_hit, req_hit_way, fill_done,
    output req_ready, victim_way, fill_req, fill_index, wr_en, miss_count, hit_count
  );

  modport master (
    output req_valid, req_index, req_hit, req_hit_way, fill_done,
    input  req_ready, victim_way, fill_req, fill_index, wr_en, miss_count, hit_count
  );
endinterface

// File: rtl/way_replace_ctrl.sv
// Two-way cache replacement controller: one LRU bit per set, miss -> fill -> commit sequencing,
// saturating hit/miss statistics. All outputs are registered.
module way_replace_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int INDEX_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  way_replace_if.slave if_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_victim_way;
  logic                r_fill_req;
  logic                r_wr_en;
  logic [INDEX_W-1:0]  r_fill_index;
  logic [15:0]         r_miss_count;
  logic [15:0]         r_hit_count;
  logic [NUM_SETS-1:0] r_lru;

  logic                w_accept;
  logic                w_lru_we;
  logic [INDEX_W-1:0]  w_lru_idx;
  logic                w_lru_d;
  logic [NUM_SETS-1:0] w_lru_next;

  // r_ready mirrors "state is IDLE" but stays low for the first cycle out of reset.
  assign w_accept = if_bus.req_valid & r_ready;

  // A commit and an accepted hit can never coincide: hits are only accepted in IDLE.
  always_comb begin
    w_lru_we  = 1'b0;
    w_lru_idx = if_bus.req_index;
    w_lru_d   = ~if_bus.req_hit_way;
    if (r_state == COMMIT) begin
      w_lru_we  = 1'b1;
      w_lru_idx = r_fill_index;
      w_lru_d   = ~r_victim_way;
    end else if (w_accept && if_bus.req_hit) begin
      w_lru_we  = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_lru
      assign w_lru_next[gi] = (w_lru_we && (w_lru_idx == INDEX_W'(gi))) ? w_lru_d : r_lru[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_victim_way <= 1'b0;
      r_fill_req   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_fill_index <= '0;
      r_miss_count <= '0;
      r_hit_count  <= '0;
      r_lru        <= '0;
    end else begin
      r_lru   <= w_lru_next;
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (if_bus.req_hit) begin
              if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
              r_fill_index <= if_bus.req_index;
              r_victim_way <= r_lru[if_bus.req_index];
              if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
              r_state      <= FILL;
              r_ready      <= 1'b0;
              r_fill_req   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (if_bus.fill_done) begin
            r_state    <= COMMIT;
            r_fill_req <= 1'b0;
            r_wr_en    <= 1'b1;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_ready    <= 1'b1;
          r_fill_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_bus.req_ready  = r_ready;
  assign if_bus.victim_way = r_victim_way;
  assign if_bus.fill_req   = r_fill_req;
  assign if_bus.fill_index = r_fill_index;
  assign if_bus.wr_en      = r_wr_en;
  assign if_bus.miss_count = r_miss_count;
  assign if_bus.hit_count  = r_hit_count;

endmodule

// File: tb/tb_way_replace_ctrl.sv
// Self-checking bench for way_replace_ctrl: a reference LRU/counter model pushes expected fill
// victims into a queue at miss time; they are popped and compared when wr_en fires.
module tb_way_replace_ctrl;
  localparam int NUM_SETS = 16;
  localparam int INDEX_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  way_replace_if #(.INDEX_W(INDEX_W)) bus ();

  way_replace_ctrl #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .if_bus(bus)
  );

  typedef struct packed {
    logic               victim;
    logic [INDEX_W-1:0] index;
  } exp_t;

  typedef struct {
    bit                 fill_ok;
    bit                 stable;
    bit                 seen;
    int                 lat;
    logic               victim;
    logic [INDEX_W-1:0] index;
    logic               fill_at_wr;
    logic               wr_after;
    logic               ready_after;
  } obs_t;

  exp_t exp_q[$];
  logic model_lru[NUM_SETS];
  int   model_hits;
  int   model_misses;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < NUM_SETS; i++) model_lru[i] = 1'b0;
    model_hits   = 0;
    model_misses = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_index   = '0;
    bus.req_hit     = 1'b0;
    bus.req_hit_way = 1'b0;
    bus.fill_done   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // Drive one hit for a single cycle (caller leaves req_valid to the next stimulus).
  task automatic drive_hit(input logic [INDEX_W-1:0] idx, input logic way, output logic ready_seen);
    @(negedge clk);
    ready_seen      = bus.req_ready;
    bus.req_valid   = 1'b1;
    bus.req_hit     = 1'b1;
    bus.req_hit_way = way;
    bus.req_index   = idx;
    model_lru[idx]  = ~way;
    if (model_hits < 65535) model_hits++;
  endtask

  // Miss on idx, fill_done n cycles after FILL entry; optional stray hit held during FILL.
  task automatic run_miss(input logic [INDEX_W-1:0] idx, input int n, input bit stray,
                          input logic [INDEX_W-1:0] stray_idx, output obs_t o);
    exp_t e;
    logic v0;
    logic [INDEX_W-1:0] i0;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_hit     = 1'b0;
    bus.req_hit_way = 1'($urandom_range(0, 1));
    bus.req_index   = idx;
    e.victim = model_lru[idx];
    e.index  = idx;
    exp_q.push_back(e);
    model_lru[idx] = ~e.victim;
    model_misses++;
    @(negedge clk);
    o.lat           = 1;
    bus.req_valid   = stray;
    bus.req_hit     = 1'b1;
    bus.req_hit_way = 1'b0;
    bus.req_index   = stray_idx;
    o.fill_ok = (bus.fill_req === 1'b1) && (bus.wr_en === 1'b0) && (bus.req_ready === 1'b0);
    v0 = bus.victim_way;
    i0 = bus.fill_index;
    o.stable = 1'b1;
    repeat (n) begin
      @(negedge clk);
      o.lat++;
      o.fill_ok = o.fill_ok && (bus.fill_req === 1'b1) && (bus.wr_en === 1'b0);
      o.stable  = o.stable && (bus.victim_way === v0) && (bus.fill_index === i0);
    end
    bus.fill_done = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.fill_done = 1'b0;
    o.lat++;
    o.seen = 1'b0;
    o.victim = 1'bx;
    o.index = 'x;
    o.fill_at_wr = 1'bx;
    for (int k = 0; k < 16 && !o.seen; k++) begin
      if (bus.wr_en === 1'b1) begin
        o.seen       = 1'b1;
        o.victim     = bus.victim_way;
        o.index      = bus.fill_index;
        o.fill_at_wr = bus.fill_req;
        o.stable     = o.stable && (bus.victim_way === v0) && (bus.fill_index === i0);
      end else begin
        @(negedge clk);
        o.lat++;
      end
    end
    @(negedge clk);
    o.wr_after    = bus.wr_en;
    o.ready_after = bus.req_ready;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.fill_req !== 1'b0) begin n_errors++; $display("FAIL reset_fill_req: got %b expected 0", bus.fill_req); end
    n_checks++; if (bus.wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    n_checks++; if ({bus.victim_way, bus.fill_index} !== 5'd0) begin n_errors++; $display("FAIL reset_victim_index: got %b/%0d expected 0/0", bus.victim_way, bus.fill_index); end
    n_checks++; if ({bus.hit_count, bus.miss_count} !== 32'd0) begin n_errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after_release: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_first_miss();
    obs_t o;
    exp_t e;
    run_miss(4'd3, 1, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=3: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL first_miss_victim: got %b expected %b", o.victim, e.victim); end
    n_checks++; if (o.index !== e.index) begin n_errors++; $display("FAIL first_miss_index: got %0d expected %0d", o.index, e.index); end
    n_checks++; if (o.lat !== 3) begin n_errors++; $display("FAIL first_miss_latency: got %0d expected 3", o.lat); end
    n_checks++; if (o.fill_ok !== 1'b1) begin n_errors++; $display("FAIL first_miss_fill_req_hold: got %b expected 1", o.fill_ok); end
    n_checks++; if (o.stable !== 1'b1) begin n_errors++; $display("FAIL first_miss_stable: got %b expected 1", o.stable); end
    n_checks++; if (o.fill_at_wr !== 1'b0) begin n_errors++; $display("FAIL first_miss_fill_wr_overlap: got %b expected 0", o.fill_at_wr); end
    n_checks++; if ({o.wr_after, o.ready_after} !== 2'b01) begin n_errors++; $display("FAIL first_miss_single_pulse: got wr=%b rdy=%b expected wr=0 rdy=1", o.wr_after, o.ready_after); end
    n_checks++; if (bus.miss_count !== 16'(model_misses)) begin n_errors++; $display("FAIL first_miss_count: got %0d expected %0d", bus.miss_count, model_misses); end
    run_miss(4'd3, 2, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=3: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL lru3_after_commit: got %b expected %b", o.victim, e.victim); end
    n_checks++; if (o.lat !== 4) begin n_errors++; $display("FAIL second_miss_latency: got %0d expected 4", o.lat); end
  endtask

  task automatic test_hit_then_miss();
    obs_t o;
    exp_t e;
    logic rdy;
    apply_reset();
    drive_hit(4'd5, 1'b0, rdy);
    $display("hit idx=5 way=0: ready=%b", rdy);
    run_miss(4'd5, 2, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=5: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL hit_miss_victim: got %b expected %b", o.victim, e.victim); end
    n_checks++; if ({bus.hit_count, bus.miss_count} !== {16'(model_hits), 16'(model_misses)}) begin n_errors++; $display("FAIL hit_miss_counts: got %0d/%0d expected %0d/%0d", bus.hit_count, bus.miss_count, model_hits, model_misses); end
    run_miss(4'd5, 1, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=5: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL lru5_after_commit: got %b expected %b", o.victim, e.victim); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic rdy;
    bit [2:0] ways = 3'b101;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_hit(4'd7, ways[i], rdy);
      $display("hit idx=7 way=%b: ready=%b", ways[i], rdy);
      n_checks++; if (rdy !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, rdy); end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.hit_count !== 16'(model_hits)) begin n_errors++; $display("FAIL b2b_hit_count: got %0d expected %0d", bus.hit_count, model_hits); end
    drive_hit(4'd7, 1'b0, rdy);
    run_miss(4'd7, 1, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=7: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL b2b_lru7: got %b expected %b", o.victim, e.victim); end
  endtask

  task automatic test_ignored();
    obs_t o;
    exp_t e;
    logic bad;
    logic rdy_ok;
    run_miss(4'd2, 3, 1'b1, 4'd4, o);
    e = exp_q.pop_front();
    $display("miss idx=2 with stray hit: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if ({o.seen, o.victim, o.index} !== {1'b1, e.victim, e.index}) begin n_errors++; $display("FAIL ignored_fill: got seen=%b %b/%0d expected 1 %b/%0d", o.seen, o.victim, o.index, e.victim, e.index); end
    n_checks++; if (bus.hit_count !== 16'(model_hits)) begin n_errors++; $display("FAIL ignored_hit_count: got %0d expected %0d", bus.hit_count, model_hits); end
    @(negedge clk);
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    bad = 1'b0;
    rdy_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bad    = bad | bus.wr_en | bus.fill_req;
      rdy_ok = rdy_ok & bus.req_ready;
    end
    $display("stray fill_done in IDLE: wr/fill seen=%b ready=%b", bad, rdy_ok);
    n_checks++; if ({bad, rdy_ok} !== 2'b01) begin n_errors++; $display("FAIL stray_fill_done: got bad=%b ready=%b expected 0/1", bad, rdy_ok); end
    run_miss(4'd4, 1, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL ignored_lru4: got %b expected %b", o.victim, e.victim); end
    n_checks++; if (bus.miss_count !== 16'(model_misses)) begin n_errors++; $display("FAIL ignored_miss_count: got %0d expected %0d", bus.miss_count, model_misses); end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic rdy;
    logic [INDEX_W-1:0] idx;
    for (int i = 0; i < 40; i++) begin
      idx = INDEX_W'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        drive_hit(idx, 1'($urandom_range(0, 1)), rdy);
        $display("rand hit idx=%0d: ready=%b", idx, rdy);
        n_checks++; if (rdy !== 1'b1) begin n_errors++; $display("FAIL rand_hit_ready_%0d: got %b expected 1", i, rdy); end
      end else begin
        run_miss(idx, $urandom_range(1, 3), 1'b0, 4'd0, o);
        e = exp_q.pop_front();
        $display("rand miss idx=%0d: victim=%b index=%0d lat=%0d", idx, o.victim, o.index, o.lat);
        n_checks++; if ({o.seen, o.victim, o.index, o.fill_at_wr} !== {1'b1, e.victim, e.index, 1'b0}) begin n_errors++; $display("FAIL rand_miss_%0d: got seen=%b %b/%0d fill=%b expected 1 %b/%0d fill=0", i, o.seen, o.victim, o.index, o.fill_at_wr, e.victim, e.index); end
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.hit_count, bus.miss_count} !== {16'(model_hits), 16'(model_misses)}) begin n_errors++; $display("FAIL rand_counts: got %0d/%0d expected %0d/%0d", bus.hit_count, bus.miss_count, model_hits, model_misses); end
  endtask

  task automatic test_reset_mid_fill();
    obs_t o;
    exp_t e;
    logic rdy;
    logic bad;
    apply_reset();
    drive_hit(4'd9, 1'b0, rdy);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_hit   = 1'b0;
    bus.req_index = 4'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if ({bus.fill_req, bus.fill_index} !== {1'b1, 4'd9}) begin n_errors++; $display("FAIL midfill_enter: got fill=%b idx=%0d expected 1/9", bus.fill_req, bus.fill_index); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-FILL: fill_req=%b wr_en=%b idx=%0d", bus.fill_req, bus.wr_en, bus.fill_index);
    n_checks++; if ({bus.fill_req, bus.wr_en, bus.victim_way, bus.fill_index} !== 7'd0) begin n_errors++; $display("FAIL midfill_reset_outputs: got fill=%b wr=%b victim=%b idx=%0d expected all 0", bus.fill_req, bus.wr_en, bus.victim_way, bus.fill_index); end
    n_checks++; if ({bus.hit_count, bus.miss_count} !== 32'd0) begin n_errors++; $display("FAIL midfill_reset_counts: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count); end
    @(negedge clk);
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    rst_n = 1'b1;
    clear_model();
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bad = bad | bus.wr_en | bus.fill_req;
    end
    n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL midfill_no_wr_en: got %b expected 0", bad); end
    run_miss(4'd9, 1, 1'b0, 4'd0, o);
    e = exp_q.pop_front();
    $display("miss idx=9 after reset: victim=%b index=%0d lat=%0d", o.victim, o.index, o.lat);
    n_checks++; if (o.victim !== e.victim) begin n_errors++; $display("FAIL midfill_lru9: got %b expected %b", o.victim, e.victim); end
    n_checks++; if (bus.miss_count !== 16'(model_misses)) begin n_errors++; $display("FAIL midfill_miss_count: got %0d expected %0d", bus.miss_count, model_misses); end
  endtask

  task automatic test_hit_saturation();
    apply_reset();
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_hit     = 1'b1;
    bus.req_hit_way = 1'b0;
    bus.req_index   = 4'd0;
    repeat (65534) @(negedge clk);
    model_hits = 65534;
    $display("hit_count preload: %h", bus.hit_count);
    n_checks++; if (bus.hit_count !== 16'hFFFE) begin n_errors++; $display("FAIL sat_preload: got %h expected fffe", bus.hit_count); end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (model_hits < 65535) model_hits++;
      $display("saturating hit %0d: hit_count=%h", j, bus.hit_count);
      n_checks++; if (bus.hit_count !== 16'(model_hits)) begin n_errors++; $display("FAIL sat_hit_%0d: got %h expected %h", j, bus.hit_count, 16'(model_hits)); end
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clear_model();
    test_reset();
    test_first_miss();
    test_hit_then_miss();
    test_back_to_back();
    test_ignored();
    test_random();
    test_reset_mid_fill();
    test_hit_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
